// File: rtl/ofmap_pkg.sv
// ofmap_pkg: shared types and constants for the ofmap write-back stage.
//   state_t      : write-back FSM states
//   SAT_MAX/MIN  : requantized output clamp limits (signed OFMAP_DATA_W)
//   round_off()  : round-half-up offset for a right shift of s bits
package ofmap_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam int OFMAP_DATA_W  = 8;
  localparam int OFMAP_PSUM_W  = 32;
  localparam int OFMAP_SHIFT_W = 5;
  localparam int SAT_MAX = (1 << (OFMAP_DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (OFMAP_DATA_W - 1));

  // Half of one output LSB, i.e. 1 << (s-1); zero when there is no shift.
  function automatic logic [OFMAP_PSUM_W:0] round_off(input logic [OFMAP_SHIFT_W-1:0] s);
    round_off = '0;
    if (s != '0) round_off[s - 1'b1] = 1'b1;
  endfunction
endpackage

// File: rtl/ofmap_writeback_requant_lane.sv
// requant_lane: one lane of psum -> 8-bit requantization (combinational).
//   p : signed partial sum (stage-1 register)
//   s : right-shift amount
//   q : rounded, optionally ReLU'd, saturated output
// Macro OFMAP_RELU_EN: clamp negative results to zero before saturation.
module requant_lane
  import ofmap_pkg::*;
#(
  parameter int PSUM_WIDTH  = OFMAP_PSUM_W,
  parameter int DATA_WIDTH  = OFMAP_DATA_W,
  parameter int SHIFT_WIDTH = OFMAP_SHIFT_W
) (
  input  logic signed [PSUM_WIDTH-1:0]  p,
  input  logic        [SHIFT_WIDTH-1:0] s,
  output logic        [DATA_WIDTH-1:0]  q
);
  logic        [PSUM_WIDTH:0] off;
  logic signed [PSUM_WIDTH:0] sum;
  logic signed [PSUM_WIDTH:0] r;

  assign off = (PSUM_WIDTH+1)'(round_off(OFMAP_SHIFT_W'(s)));

  always_comb begin
    // One extra bit so the rounding add cannot overflow near +max.
    sum = $signed({p[PSUM_WIDTH-1], p}) + $signed(off);
    r   = sum >>> s;
`ifdef OFMAP_RELU_EN
    if (r < 0) r = '0;
`endif
    if (r > $signed((PSUM_WIDTH+1)'(SAT_MAX)))      q = DATA_WIDTH'(SAT_MAX);
    else if (r < $signed((PSUM_WIDTH+1)'(SAT_MIN))) q = DATA_WIDTH'(SAT_MIN);
    else                                            q = r[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: drains ROW_NUM psum rows from the ACC FIFO, requantizes
// every lane to DATA_WIDTH bits and writes packed rows to the ofmap buffer at
// base, base+1, ... (wrapping). Pipeline: rden -> data -> stage1 -> write reg.
// Ports:
//   en_i/shift_i/base_addr_i : tile start, latched in IDLE only
//   acc_empty_i/psum_row_i   : ACC FIFO status / read data (1 cycle after rden_o)
//   rden_o                   : ACC FIFO read strobe
//   mem_ce_o/mem_we_o/mem_addr_o/mem_d_o : output buffer write port
//   busy_o/done_o            : status; done_o pulses 1 cycle after last write
// Macro OFMAP_RELU_EN (in requant_lane): ReLU before saturation.
module ofmap_writeback
  import ofmap_pkg::*;
#(
  parameter int PE_SIZE     = 14,
  parameter int DATA_WIDTH  = OFMAP_DATA_W,
  parameter int PSUM_WIDTH  = OFMAP_PSUM_W,
  parameter int ROW_NUM     = 64,
  parameter int ADDR_WIDTH  = 11,
  parameter int SHIFT_WIDTH = OFMAP_SHIFT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic                          acc_empty_i,
  input  logic [PE_SIZE*PSUM_WIDTH-1:0] psum_row_i,
  output logic                          rden_o,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [PE_SIZE*DATA_WIDTH-1:0] mem_d_o,
  output logic                          busy_o,
  output logic                          done_o
);
  localparam int CNT_W  = $clog2(ROW_NUM + 1);
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] ROWS = CNT_W'(ROW_NUM);

  state_t state, state_nx;
  logic [CNT_W-1:0]       rd_cnt, wr_cnt;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  // [1]: FIFO data valid on psum_row_i, [2]: stage-1 register valid
  logic [STAGES:1]        vld_pipe;
  logic [PE_SIZE-1:0][PSUM_WIDTH-1:0] st1;
  logic [PE_SIZE-1:0][DATA_WIDTH-1:0] q_lane;
  logic start;

  assign start  = (state == IDLE) && en_i;
  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  always_comb begin
    state_nx = state;
    rden_o   = 1'b0;
    case (state)
      IDLE:  if (en_i) state_nx = READ;
      READ: begin
        rden_o = !acc_empty_i && (rd_cnt < ROWS);
        if (rd_cnt == ROWS) state_nx = DRAIN;
      end
      DRAIN: if (wr_cnt == ROWS) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      base_q     <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      vld_pipe   <= '0;
      st1        <= '0;
      mem_ce_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_d_o    <= '0;
    end else begin
      if (start) begin
        shift_q <= shift_i;
        base_q  <= base_addr_i;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
      end else begin
        if (rden_o)      rd_cnt <= rd_cnt + 1'b1;
        if (vld_pipe[2]) wr_cnt <= wr_cnt + 1'b1;
      end
      vld_pipe <= {vld_pipe[1], rden_o};
      if (vld_pipe[1]) st1 <= psum_row_i;
      // Writes are never stalled: every valid row leaves the pipe in order.
      mem_ce_o <= vld_pipe[2];
      mem_we_o <= vld_pipe[2];
      if (vld_pipe[2]) begin
        mem_addr_o <= base_q + ADDR_WIDTH'(wr_cnt);
        mem_d_o    <= q_lane;
      end
    end
  end

  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    requant_lane #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .p(st1[k]),
      .s(shift_q),
      .q(q_lane[k])
    );
  end
endmodule

// File: tb/tb_ofmap_writeback.sv
module tb_ofmap_writeback;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel, en, empty;
  logic [4:0]  shift;
  logic [10:0] base;
  logic [127:0] psum_a, psum_b;
  logic [127:0] rows [16];
  int ptr_a = 0, ptr_b = 0, p0 = 0;

  logic rden_a, ce_a, we_a, busy_a, done_a;
  logic rden_b, ce_b, we_b, busy_b, done_b;
  logic [10:0] addr_a, addr_b;
  logic [31:0] d_a, d_b;

  ofmap_writeback #(.PE_SIZE(4), .ROW_NUM(4)) dut_a (
    .clk(clk), .rst(rst), .en_i(en & ~sel), .shift_i(shift), .base_addr_i(base),
    .acc_empty_i(empty), .psum_row_i(psum_a), .rden_o(rden_a), .mem_ce_o(ce_a),
    .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_d_o(d_a), .busy_o(busy_a), .done_o(done_a));

  ofmap_writeback #(.PE_SIZE(4), .ROW_NUM(8)) dut_b (
    .clk(clk), .rst(rst), .en_i(en & sel), .shift_i(shift), .base_addr_i(base),
    .acc_empty_i(empty), .psum_row_i(psum_b), .rden_o(rden_b), .mem_ce_o(ce_b),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_d_o(d_b), .busy_o(busy_b), .done_o(done_b));

  // ACC FIFO models: read data appears the cycle after the strobe.
  always @(posedge clk) if (rden_a === 1'b1) begin
    psum_a <= rows[(ptr_a - p0) & 15];
    ptr_a  <= ptr_a + 1;
  end
  always @(posedge clk) if (rden_b === 1'b1) begin
    psum_b <= rows[(ptr_b - p0) & 15];
    ptr_b  <= ptr_b + 1;
  end

  logic rden, ce, we, busy, done;
  logic [10:0] addr;
  logic [31:0] d;
  assign rden = sel ? rden_b : rden_a;
  assign ce   = sel ? ce_b   : ce_a;
  assign we   = sel ? we_b   : we_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign addr = sel ? addr_b : addr_a;
  assign d    = sel ? d_b    : d_a;

  int checks = 0, errors = 0;
  int w_n, done_n, done_cyc, rden_bad, we_bad;
  logic [10:0] w_addr [16];
  logic [31:0] w_d [16];
  int w_cyc [16];

  function automatic logic [127:0] pk32(int l0, int l1, int l2, int l3);
    return {l3, l2, l1, l0};
  endfunction
  function automatic logic [31:0] pk8(int l0, int l1, int l2, int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction
  function automatic int relu(int v);
`ifdef OFMAP_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Stimulus and write capture only; comparisons live in the test tasks.
  task automatic run_tile(input logic s, input logic [4:0] sh, input logic [10:0] b,
                          input bit toggle, input int en_mid, input int stop_after);
    int last;
    sel = s; p0 = s ? ptr_b : ptr_a;
    w_n = 0; done_n = 0; done_cyc = -1; rden_bad = 0; we_bad = 0; last = 80;
    en = 1'b1; shift = sh; base = b; empty = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      en = 1'b0;
      if (c == 0) begin shift = 5'd9; base = 11'h3AA; end
      if (rden === 1'b1 && empty) rden_bad++;
      if (ce !== we) we_bad++;
      if (ce === 1'b1) begin
        if (w_n < 16) begin w_addr[w_n] = addr; w_d[w_n] = d; w_cyc[w_n] = c; end
        w_n++;
      end
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) begin done_cyc = c; last = c + 3; end
      end
      if (stop_after > 0 && w_n == stop_after) return;
      empty = toggle ? (((c / 2) % 2) == 0) : 1'b0;
      if (c == en_mid) begin en = 1'b1; shift = 5'd7; base = 11'h055; end
    end
  endtask

  task automatic test_reset();
    sel = 0; en = 0; empty = 0; shift = 0; base = 0; rst = 1'b1;
    #12;
    checks++;
    if ({rden_a, ce_a, we_a, busy_a, done_a, rden_b, busy_b, done_b} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {rden_a, ce_a, we_a, busy_a, done_a, rden_b, busy_b, done_b});
    end
    checks++;
    if ({addr_a, d_a} !== 43'b0) begin
      errors++; $display("FAIL reset_data got addr %h d %h want 0", addr_a, d_a);
    end
    @(negedge clk); rst = 1'b0; @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) rows[i] = pk32(5 + i, -3, 127, -128);
    run_tile(0, 5'd0, 11'h010, 0, -1, -1);
    checks++;
    if (w_n !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", w_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (w_addr[i] !== 11'h010 + 11'(i) || w_d[i] !== pk8(5 + i, relu(-3), 127, relu(-128))) begin
        errors++; $display("FAIL basic_row%0d got addr %h d %h want %h %h", i, w_addr[i], w_d[i],
                           11'h010 + 11'(i), pk8(5 + i, relu(-3), 127, relu(-128)));
      end
      checks++;
      if (w_cyc[i] !== w_cyc[0] + i) begin
        errors++; $display("FAIL basic_b2b%0d got cyc %0d want %0d", i, w_cyc[i], w_cyc[0] + i);
      end
    end
    checks++;
    if (done_n !== 1 || done_cyc !== w_cyc[3] + 1) begin
      errors++; $display("FAIL basic_done got n %0d cyc %0d want 1 %0d", done_n, done_cyc, w_cyc[3] + 1);
    end
    checks++;
    if (we_bad !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_we_busy got we_bad %0d busy %b want 0 0", we_bad, busy);
    end
  endtask

  task automatic test_round();
    for (int i = 0; i < 16; i++) rows[i] = pk32(8, 7, -8, -9);
    run_tile(0, 5'd4, 11'h020, 0, -1, -1);
    checks++;
    if (w_n !== 4 || w_d[0] !== pk8(1, 0, 0, relu(-1)) || w_d[3] !== pk8(1, 0, 0, relu(-1))) begin
      errors++; $display("FAIL round_s4 got n %0d d %h/%h want 4 %h", w_n, w_d[0], w_d[3], pk8(1, 0, 0, relu(-1)));
    end
    for (int i = 0; i < 16; i++) rows[i] = pk32(-3, -1, 3, 1);
    run_tile(0, 5'd1, 11'h020, 0, -1, -1);
    checks++;
    if (w_n !== 4 || w_d[1] !== pk8(relu(-1), 0, 2, 1)) begin
      errors++; $display("FAIL round_s1 got n %0d d %h want 4 %h", w_n, w_d[1], pk8(relu(-1), 0, 2, 1));
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 16; i++) rows[i] = pk32(300, -300, 32'h7FFFFFFF, 32'h80000000);
    run_tile(0, 5'd0, 11'h030, 0, -1, -1);
    checks++;
    if (w_n !== 4 || w_d[2] !== pk8(127, relu(-128), 127, relu(-128))) begin
      errors++; $display("FAIL sat_s0 got n %0d d %h want 4 %h", w_n, w_d[2], pk8(127, relu(-128), 127, relu(-128)));
    end
    run_tile(0, 5'd31, 11'h030, 0, -1, -1);
    checks++;
    if (w_d[0] !== pk8(0, 0, 1, relu(-1))) begin
      errors++; $display("FAIL sat_s31 got %h want %h", w_d[0], pk8(0, 0, 1, relu(-1)));
    end
  endtask

  task automatic test_empty_toggle();
    for (int i = 0; i < 16; i++) rows[i] = pk32(i + 1, -2 * (i + 1), 10 * i, -7);
    run_tile(1, 5'd0, 11'h100, 1, -1, -1);
    checks++;
    if (w_n !== 8 || done_n !== 1) begin
      errors++; $display("FAIL gap_count got n %0d done %0d want 8 1", w_n, done_n);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (w_addr[i] !== 11'h100 + 11'(i) || w_d[i] !== pk8(i + 1, relu(-2 * (i + 1)), 10 * i, relu(-7))) begin
        errors++; $display("FAIL gap_row%0d got addr %h d %h want %h %h", i, w_addr[i], w_d[i],
                           11'h100 + 11'(i), pk8(i + 1, relu(-2 * (i + 1)), 10 * i, relu(-7)));
      end
    end
    checks++;
    if (rden_bad !== 0) begin errors++; $display("FAIL gap_rden_when_empty got %0d want 0", rden_bad); end
    sel = 0;
  endtask

  task automatic test_wrap();
    logic [10:0] exp_a [4];
    exp_a[0] = 11'd2046; exp_a[1] = 11'd2047; exp_a[2] = 11'd0; exp_a[3] = 11'd1;
    for (int i = 0; i < 16; i++) rows[i] = pk32(100 + i, 40, 1, 2);
    run_tile(0, 5'd0, 11'd2046, 0, 2, -1);
    checks++;
    if (w_n !== 4 || done_n !== 1) begin
      errors++; $display("FAIL wrap_count got n %0d done %0d want 4 1", w_n, done_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (w_addr[i] !== exp_a[i] || w_d[i] !== pk8(100 + i, 40, 1, 2)) begin
        errors++; $display("FAIL wrap_row%0d got addr %h d %h want %h %h", i, w_addr[i], w_d[i],
                           exp_a[i], pk8(100 + i, 40, 1, 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    for (int i = 0; i < 16; i++) rows[i] = pk32(20 + i, 0, 0, 0);
    run_tile(0, 5'd0, 11'h200, 0, -1, 2);
    checks++;
    if (w_n !== 2) begin errors++; $display("FAIL rstmid_pre got n %0d want 2", w_n); end
    rst = 1'b1;
    #1;
    checks++;
    if ({rden_a, ce_a, we_a, busy_a, done_a} !== 5'b0 || addr_a !== 11'd0 || d_a !== 32'd0) begin
      errors++; $display("FAIL rstmid_async got ctrl %b addr %h d %h want 0", {rden_a, ce_a, we_a, busy_a, done_a}, addr_a, d_a);
    end
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      if (ce_a !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL rstmid_stray got %0d want 0", stray); end
    run_tile(0, 5'd0, 11'h040, 0, -1, -1);
    checks++;
    if (w_n !== 4 || w_addr[0] !== 11'h040 || w_addr[3] !== 11'h043 || w_d[0] !== pk8(20, 0, 0, 0)) begin
      errors++; $display("FAIL rstmid_fresh got n %0d a %h..%h d %h want 4 040..043 %h",
                         w_n, w_addr[0], w_addr[3], w_d[0], pk8(20, 0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_empty_toggle();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofmap_writeback.md
# ofmap_writeback

Output-side stage that drains finished partial-sum rows from the accumulator FIFO behind the systolic array and requantizes each lane to the 8-bit ifmap format. Each lane's 32-bit psum is shifted right with rounding and saturated. Each packed row is written to the output feature-map buffer at consecutive addresses. One start pulse processes one tile of ROW_NUM rows.

## Interface
Parameters:
- PE_SIZE, 14, lanes per row (systolic array width)
- DATA_WIDTH, 8, output element width (signed)
- PSUM_WIDTH, 32, input partial-sum width (signed)
- ROW_NUM, 64, rows drained per tile (OC)
- ADDR_WIDTH, 11, output buffer address width
- SHIFT_WIDTH, 5, width of requant shift amount

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- en_i  in  1  start pulse; accepted only in IDLE
- shift_i  in  SHIFT_WIDTH  right-shift amount; sampled on accepted en_i
- base_addr_i  in  ADDR_WIDTH  first write address; sampled on accepted en_i
- acc_empty_i  in  1  ACC FIFO empty
- psum_row_i  in  PE_SIZE*PSUM_WIDTH  ACC read data; valid the cycle after rden_o
- rden_o  out  1  ACC FIFO read strobe
- mem_ce_o, mem_we_o  out  1  output buffer chip/write enable (identical)
- mem_addr_o  out  ADDR_WIDTH  write address
- mem_d_o  out  PE_SIZE*DATA_WIDTH  packed requantized row
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after last write

## Operation
- Lane k occupies bits [k*W +: W], with lane 0 at the LSB, on both psum_row_i and mem_d_o.
- The FSM has four states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ on en_i. On entry, shift and base are latched and the read counter and write counter are cleared.
- READ: rden_o = !acc_empty_i && rd_cnt < ROW_NUM; rd_cnt increments on each rden_o. The FSM goes to DRAIN when rd_cnt reaches ROW_NUM.
- DRAIN: waits until wr_cnt == ROW_NUM, then goes to DONE.
- DONE: asserts done_o for one cycle, then returns to IDLE.
- en_i outside IDLE is ignored; the latched shift and base stay unchanged.
- Requant per lane, with s = latched shift:
  - The sum is computed at PSUM_WIDTH+1 bits signed: r = (p + (s ? 1<<(s-1) : 0)) >>> s.
  - The rounding is round-half-up toward +inf.
  - r is then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Write address = base + wr_cnt, wrapping modulo 2^ADDR_WIDTH. wr_cnt increments on each write.

## Timing
- Pipeline, for rden_o in cycle T:
  - psum_row_i is valid in T+1 and captured in stage 1.
  - Shift/round is registered at the end of T+2.
  - Saturate drives the write registers, so mem_ce_o/mem_we_o/mem_addr_o/mem_d_o are asserted in T+3.
- Latency rden_o -> write is 3 cycles. Throughput is one row per cycle while acc_empty_i = 0.
- acc_empty_i rising mid-tile: rden_o drops in the same cycle. Rows already in flight still complete. Writes are never stalled.
- done_o comes 1 cycle after the last write. A new en_i is accepted the cycle after done_o at the earliest.
- Reset values: rden_o, mem_ce_o, mem_we_o, busy_o, done_o = 0; mem_addr_o = 0; mem_d_o = 0; FSM = IDLE; counters = 0.
- Reset mid-tile: abort immediately with no further writes. ACC contents are not flushed.
- ROW_NUM rows are written exactly once per tile, with no duplicates or skips across FIFO empty gaps.

## Configuration
- OFMAP_RELU_EN defined: negative r is clamped to 0 before saturation, so the output range is [0, 2^(DATA_WIDTH-1)-1].
- OFMAP_RELU_EN undefined: full signed saturation as in Operation.

## Structure
- Package ofmap_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - localparams SAT_MAX and SAT_MIN derived from DATA_WIDTH;
  - the rounding-offset helper function.
- Sub-module requant_lane implements shift, round, ReLU and saturate for one lane (stage-2 and stage-3 logic). It is generated PE_SIZE times.
- The top holds the FSM, counters, the stage-1 capture and valid shift register, and the write registers.

## Test plan
- PE_SIZE=4, ROW_NUM=4, shift=0, base=0x10, FIFO never empty, lanes {5,-3,127,-128}:
  - Required: writes at 0x10..0x13 in consecutive cycles with mem_d_o lanes {5,-3,127,-128} (RELU off).
  - Required: done_o pulses 1 cycle after the 0x13 write.
- Rounding, shift=4, lanes {8,7,-8,-9}:
  - Required: {1,0,0,-1}.
- Saturation, shift=0, lanes {300,-300,0x7FFFFFFF,0x80000000}:
  - Required: {127,-128,127,-128} without OFMAP_RELU_EN.
  - Required: {127,0,127,0} with OFMAP_RELU_EN.
- acc_empty_i toggles 1/0 every 2 cycles over ROW_NUM=8:
  - Required: exactly 8 writes in row order and contiguous addresses.
  - Required: rden_o is never high while acc_empty_i is high.
- base=2^ADDR_WIDTH-2, ROW_NUM=4:
  - Required: addresses wrap to 2^ADDR_WIDTH-2, -1, 0, 1.
  - Required: en_i pulsed mid-tile is ignored.
- rst asserted after 2 of 4 writes:
  - Required: all outputs 0 asynchronously and no further writes.
  - Required: a subsequent en_i starts a fresh tile at its own base.
